// File: rtl/dense_3_argmax_if.sv
// Score write stream and argmax result handshake between the dense_3 layer
// output and the argmax stage.
interface dense_3_argmax_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 8
);
  logic                  in_wr_en;
  logic [31:0]           in_wr_addr;
  logic [DATA_WIDTH-1:0] in_wr_data;
  logic                  result_valid;
  logic                  result_ready;
  logic [IDX_WIDTH-1:0]  class_idx;
  logic [DATA_WIDTH-1:0] class_score;

  modport master (
    output in_wr_en, in_wr_addr, in_wr_data, result_ready,
    input  result_valid, class_idx, class_score
  );

  modport slave (
    input  in_wr_en, in_wr_addr, in_wr_data, result_ready,
    output result_valid, class_idx, class_score
  );
endinterface

// File: rtl/dense_3_argmax.sv
// Collects CLASS_NUM signed scores from dense_3, tracks the running maximum
// and presents the winning class with a valid/ready handshake.
module dense_3_argmax #(
  parameter int CLASS_NUM  = 43,
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  dense_3_argmax_if.slave       bus,
  input  logic [IDX_WIDTH-1:0]  score_rd_addr,
  output logic [DATA_WIDTH-1:0] score_rd_data,
  output logic                  addr_err,
  output logic                  busy
);

  localparam int          BUF_AW      = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1;
  localparam logic [31:0] CLASS_LIMIT = 32'(CLASS_NUM);
  localparam logic [7:0]  LAST_COUNT  = 8'(CLASS_NUM - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, RESULT, DONE} state_t;

  state_t                state;
  logic [7:0]            count;
  logic [DATA_WIDTH-1:0] score_buf [CLASS_NUM];
  logic                  wr_addr_ok;
  logic                  rd_addr_ok;
  logic                  wr_accept;

  assign wr_addr_ok = (bus.in_wr_addr < CLASS_LIMIT);
  assign rd_addr_ok = ({{(32-IDX_WIDTH){1'b0}}, score_rd_addr} < CLASS_LIMIT);
  assign wr_accept  = en && (state == COLLECT) && bus.in_wr_en && wr_addr_ok;
  assign busy       = (state == COLLECT);

  // Score storage has no reset; stale contents are never read as a result.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      score_buf[bus.in_wr_addr[BUF_AW-1:0]] <= bus.in_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_rd_data <= '0;
    end else if (rd_addr_ok) begin
      score_rd_data <= score_buf[score_rd_addr[BUF_AW-1:0]];
    end else begin
      score_rd_data <= '0;
    end
  end

  // Dropping en from any state abandons the inference and clears the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      count            <= '0;
      addr_err         <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.class_idx    <= '0;
      bus.class_score  <= '0;
    end else if (!en) begin
      state            <= IDLE;
      count            <= '0;
      addr_err         <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.class_idx    <= '0;
      bus.class_score  <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= COLLECT;
        end
        COLLECT: begin
          if (bus.in_wr_en && !wr_addr_ok) begin
            addr_err <= 1'b1;
          end
          if (wr_accept) begin
            count <= count + 8'd1;
            // Strict compare so a tie keeps the earlier-accepted class.
            if ((count == 8'd0) ||
                ($signed(bus.in_wr_data) > $signed(bus.class_score))) begin
              bus.class_idx   <= bus.in_wr_addr[IDX_WIDTH-1:0];
              bus.class_score <= bus.in_wr_data;
            end
            if (count == LAST_COUNT) begin
              state            <= RESULT;
              bus.result_valid <= 1'b1;
            end
          end
        end
        RESULT: begin
          if (bus.result_ready) begin
            state            <= DONE;
            bus.result_valid <= 1'b0;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dense_3_argmax.sv
// Directed bench for dense_3_argmax: full passes, ties, bad addresses,
// stalled handshake, aborted passes and score readback.
module tb_dense_3_argmax;

  localparam int CLASS_NUM  = 43;
  localparam int DATA_WIDTH = 16;
  localparam int IDX_WIDTH  = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  en;
  logic [IDX_WIDTH-1:0]  score_rd_addr;
  logic [DATA_WIDTH-1:0] score_rd_data;
  logic                  addr_err;
  logic                  busy;

  dense_3_argmax_if #(.DATA_WIDTH(DATA_WIDTH), .IDX_WIDTH(IDX_WIDTH)) bus ();

  dense_3_argmax #(
    .CLASS_NUM (CLASS_NUM),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .bus          (bus),
    .score_rd_addr(score_rd_addr),
    .score_rd_data(score_rd_data),
    .addr_err     (addr_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int                    assert_count = 0;
  int                    fail_count   = 0;
  logic [DATA_WIDTH-1:0] model_buf [CLASS_NUM];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int addr, input int data);
    bus.in_wr_en   = 1'b1;
    bus.in_wr_addr = 32'(addr);
    bus.in_wr_data = 16'(data);
    @(negedge clk);
    bus.in_wr_en   = 1'b0;
  endtask

  task automatic startPass();
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n            = 1'b0;
    en               = 1'b0;
    bus.in_wr_en     = 1'b0;
    bus.in_wr_addr   = '0;
    bus.in_wr_data   = '0;
    bus.result_ready = 1'b1;
    score_rd_addr    = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 32'(bus.result_valid), 32'd0);
    checkOutput("rst_idx", 32'(bus.class_idx), 32'd0);
    checkOutput("rst_score", 32'(bus.class_score), 32'd0);
    checkOutput("rst_addr_err", 32'(addr_err), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rd_data", 32'(score_rd_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ascending scores 10*i: last class wins, one-cycle valid pulse.
    en = 1'b1;
    @(negedge clk);
    checkOutput("p1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < CLASS_NUM; i++) begin
      applyStimulus(i, 10 * i);
      model_buf[i] = 16'(10 * i);
    end
    checkOutput("p1_valid", 32'(bus.result_valid), 32'd1);
    checkOutput("p1_idx", 32'(bus.class_idx), 32'd42);
    checkOutput("p1_score", 32'(bus.class_score), 32'd420);
    checkOutput("p1_busy_after", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("p1_valid_drop", 32'(bus.result_valid), 32'd0);
    checkOutput("p1_idx_hold", 32'(bus.class_idx), 32'd42);
    for (int i = 0; i < CLASS_NUM; i++) begin
      score_rd_addr = 8'(i);
      @(negedge clk);
      checkOutput($sformatf("p1_rd_%0d", i), 32'(score_rd_data), 32'(model_buf[i]));
    end
    score_rd_addr = 8'd43;
    @(negedge clk);
    checkOutput("p1_rd_oob", 32'(score_rd_data), 32'd0);

    // Tie between classes 7 and 30: earlier class kept.
    startPass();
    for (int i = 0; i < CLASS_NUM; i++) begin
      applyStimulus(i, (i == 7 || i == 30) ? 32'h0100 : 0);
    end
    checkOutput("tie_valid", 32'(bus.result_valid), 32'd1);
    checkOutput("tie_idx", 32'(bus.class_idx), 32'd7);
    checkOutput("tie_score", 32'(bus.class_score), 32'h0100);

    // Scores 5*i-100 (signed) with an out-of-range write mixed in.
    startPass();
    for (int i = 0; i < CLASS_NUM; i++) begin
      if (i == 10) begin
        applyStimulus(50, 32'h7FFF);
        checkOutput("bad_addr_err", 32'(addr_err), 32'd1);
      end
      applyStimulus(i, 5 * i - 100);
      if (i == 41) begin
        checkOutput("bad_no_early_valid", 32'(bus.result_valid), 32'd0);
      end
    end
    checkOutput("bad_valid", 32'(bus.result_valid), 32'd1);
    checkOutput("bad_idx", 32'(bus.class_idx), 32'd42);
    checkOutput("bad_score", 32'(bus.class_score), 32'd110);
    checkOutput("bad_err_sticky", 32'(addr_err), 32'd1);
    en = 1'b0;
    @(negedge clk);
    checkOutput("bad_err_clear", 32'(addr_err), 32'd0);
    checkOutput("bad_valid_clear", 32'(bus.result_valid), 32'd0);
    checkOutput("bad_idx_clear", 32'(bus.class_idx), 32'd0);

    // Consumer stalls five cycles; writes during RESULT/DONE are ignored.
    bus.result_ready = 1'b0;
    startPass();
    for (int i = 0; i < CLASS_NUM; i++) begin
      applyStimulus(i, (i == 17) ? 32'h7FFF : i);
      model_buf[i] = (i == 17) ? 16'h7FFF : 16'(i);
    end
    checkOutput("stall_valid_first", 32'(bus.result_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) applyStimulus(5, 32'h1234);
      else @(negedge clk);
      checkOutput($sformatf("stall_valid_%0d", k), 32'(bus.result_valid), 32'd1);
      checkOutput($sformatf("stall_idx_%0d", k), 32'(bus.class_idx), 32'd17);
      checkOutput($sformatf("stall_score_%0d", k), 32'(bus.class_score), 32'h7FFF);
    end
    bus.result_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_valid_drop", 32'(bus.result_valid), 32'd0);
    applyStimulus(6, 32'h7FFF);
    checkOutput("done_idx_hold", 32'(bus.class_idx), 32'd17);
    checkOutput("done_score_hold", 32'(bus.class_score), 32'h7FFF);
    checkOutput("done_busy", 32'(busy), 32'd0);
    score_rd_addr = 8'd5;
    @(negedge clk);
    checkOutput("done_rd_5", 32'(score_rd_data), 32'd5);
    score_rd_addr = 8'd6;
    @(negedge clk);
    checkOutput("done_rd_6", 32'(score_rd_data), 32'd6);
    score_rd_addr = 8'd17;
    @(negedge clk);
    checkOutput("done_rd_17", 32'(score_rd_data), 32'h7FFF);

    // Aborted pass: 20 writes with a large score, then en drop and a fresh pass.
    startPass();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i, (i == 3) ? 32'h7000 : i);
    end
    checkOutput("abort_no_valid", 32'(bus.result_valid), 32'd0);
    en = 1'b0;
    @(negedge clk);
    checkOutput("abort_idx_clear", 32'(bus.class_idx), 32'd0);
    checkOutput("abort_score_clear", 32'(bus.class_score), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < CLASS_NUM; i++) begin
      applyStimulus(i, (i == 25) ? 32'h0200 : 1);
    end
    checkOutput("second_valid", 32'(bus.result_valid), 32'd1);
    checkOutput("second_idx", 32'(bus.class_idx), 32'd25);
    checkOutput("second_score", 32'(bus.class_score), 32'h0200);

    // Reset mid-collect aborts the inference and clears all outputs.
    startPass();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i, 32'h0300);
    end
    applyStimulus(60, 0);
    checkOutput("mid_addr_err", 32'(addr_err), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_err", 32'(addr_err), 32'd0);
    checkOutput("mid_rst_idx", 32'(bus.class_idx), 32'd0);
    checkOutput("mid_rst_score", 32'(bus.class_score), 32'd0);
    checkOutput("mid_rst_rd", 32'(score_rd_data), 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_idle", 32'(busy), 32'd0);
    checkOutput("post_rst_valid", 32'(bus.result_valid), 32'd0);
    en = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_collect", 32'(busy), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
